// File: rtl/instruction_queue.sv
// Prefetch byte queue: circular byte buffer feeding a 16-byte decode window.
// Optional same-cycle bypass of the first beat into an empty queue: INSTRUCTION_QUEUE_BYPASS_EN.
module instruction_queue #(
  parameter int DEPTH  = 32,
  parameter int WINDOW = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_fetch_valid,
  input  logic [31:0]                i_fetch_data,
  input  logic [2:0]                 i_fetch_byte_count,
  output logic                       o_fetch_ready,
  output logic [7:0]                 o_instruction [0:WINDOW-1],
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_consume_valid,
  input  logic [4:0]                 i_consume_length,
  output logic                       o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

  logic [7:0]    r_buf [0:DEPTH-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_error;

  logic          w_fetch_ready;
  logic          w_fetch_accept;
  logic          w_count_ok;
  logic          w_write;
  logic [CW-1:0] w_wr_bytes;
  logic [CW-1:0] w_avail;
  logic          w_len_ok;
  logic          w_consume;
  logic [CW-1:0] w_rd_bytes;
  logic          w_illegal;
  logic [7:0]    w_beat [0:3];

  // Handshake: a beat transfers on a rising edge where i_fetch_valid and
  // o_fetch_ready are both high; ready depends only on registered count, so
  // a producer seeing ready low must hold the beat until it rises.
  assign w_fetch_ready  = (r_count <= READY_MAX);
  assign w_fetch_accept = i_fetch_valid & w_fetch_ready;
  assign w_count_ok     = (i_fetch_byte_count >= 3'd1) && (i_fetch_byte_count <= 3'd4);
  assign w_write        = w_fetch_accept & w_count_ok & ~i_flush;
  assign w_wr_bytes     = w_write ? CW'(i_fetch_byte_count) : '0;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_fetch_accept & w_count_ok & ~i_flush & (r_count == '0);
  assign w_avail  = w_bypass ? CW'(i_fetch_byte_count) : r_count;
`else
  assign w_avail  = r_count;
`endif

  assign w_len_ok   = (i_consume_length >= 5'd1) && (i_consume_length <= 5'd15) &&
                      (CW'(i_consume_length) <= w_avail);
  assign w_consume  = i_consume_valid & w_len_ok & ~i_flush;
  assign w_rd_bytes = w_consume ? CW'(i_consume_length) : '0;
  assign w_illegal  = (w_fetch_accept & ~w_count_ok) | (i_consume_valid & ~w_len_ok);

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_beat[n] = i_fetch_data[8*n +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_wr_bytes[PW-1:0];
      r_rd_ptr <= r_rd_ptr + w_rd_bytes[PW-1:0];
      r_count  <= r_count + w_wr_bytes - w_rd_bytes;
      if (w_illegal) begin
        r_error <= 1'b1;
      end
    end
  end

  // Byte storage carries no reset; the window masks anything beyond count.
  always_ff @(posedge clock) begin
    if (w_write) begin
      for (int n = 0; n < 4; n++) begin
        if (3'(n) < i_fetch_byte_count) begin
          r_buf[r_wr_ptr + PW'(n)] <= w_beat[n];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WINDOW; k++) begin
      o_instruction[k] = (CW'(k) < r_count) ? r_buf[r_rd_ptr + PW'(k)] : 8'h00;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
      if (w_bypass) begin
        o_instruction[k] = ((k < 4) && (3'(k) < i_fetch_byte_count)) ? w_beat[k[1:0]] : 8'h00;
      end
`endif
    end
  end

  assign o_fetch_ready = w_fetch_ready;
  assign o_count       = w_avail;
  assign o_error       = r_error;

endmodule
